// File: rtl/wb_pkg.sv
// Shared types and sizes for the register-file write-port arbiter.
package wb_pkg;

  localparam int DATA_W     = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dst;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Write-side bus between the pipeline/long-latency producers and the arbiter.
interface wb_port_arbiter_if #(
  parameter int DATA_W     = wb_pkg::DATA_W,
  parameter int ADDR_W     = wb_pkg::REG_ADDR_W,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                        pipe_valid;
  logic [ADDR_W-1:0]           pipe_dst;
  logic [DATA_W-1:0]           pipe_data;
  logic                        lu_valid;
  logic                        lu_ready;
  logic [ADDR_W-1:0]           lu_dst;
  logic [DATA_W-1:0]           lu_data;
  logic                        issue_valid;
  logic [ADDR_W-1:0]           issue_dst;
  logic [wb_pkg::NUM_REGS-1:0] busy_vec;
  logic                        regwrite_wb;
  logic [ADDR_W-1:0]           dst_wb;
  logic [DATA_W-1:0]           regwd_wb;
  logic [CNT_W-1:0]            fifo_count;

  modport master (
    output pipe_valid, pipe_dst, pipe_data,
    output lu_valid, lu_dst, lu_data,
    output issue_valid, issue_dst,
    input  lu_ready, busy_vec, regwrite_wb, dst_wb, regwd_wb, fifo_count
  );

  modport slave (
    input  pipe_valid, pipe_dst, pipe_data,
    input  lu_valid, lu_dst, lu_data,
    input  issue_valid, issue_dst,
    output lu_ready, busy_vec, regwrite_wb, dst_wb, regwd_wb, fifo_count
  );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering long-latency results until the write port is free.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        push,
  input  logic                        pop,
  input  wb_entry_t                   din,
  output wb_entry_t                   dout,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        full,
  output logic                        empty
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  wb_entry_t        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // Power-of-two depth lets the binary pointers wrap for free.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Merges pipeline WB and long-latency results onto one register-file write port.
// Define WB_FIFO_BYPASS_EN to let an lu result skip the empty FIFO (1-cycle latency).
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W     = wb_pkg::DATA_W,
  parameter int ADDR_W     = wb_pkg::REG_ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              rstn,
  wb_port_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  wb_entry_t         fifo_din, fifo_dout;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              lu_accept, bypass;

  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [DATA_W-1:0] regwd_q, regwd_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  assign bus.lu_ready = rstn & ~fifo_full;
  assign lu_accept    = bus.lu_valid & bus.lu_ready;

`ifdef WB_FIFO_BYPASS_EN
  assign bypass = lu_accept & fifo_empty & ~bus.pipe_valid;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = lu_accept & ~bypass;
  assign fifo_pop  = ~bus.pipe_valid & ~fifo_empty;
  assign fifo_din  = '{dst: bus.lu_dst, data: bus.lu_data};

  wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Pipeline always wins; busy set is applied last so a fresh issue outlives a same-cycle clear.
  always_comb begin
    regwrite_d = 1'b0;
    dst_d      = dst_q;
    regwd_d    = regwd_q;
    busy_d     = busy_q;
    if (bus.pipe_valid) begin
      regwrite_d = 1'b1;
      dst_d      = bus.pipe_dst;
      regwd_d    = bus.pipe_data;
    end else if (fifo_pop) begin
      regwrite_d             = (fifo_dout.dst != '0);
      dst_d                  = fifo_dout.dst;
      regwd_d                = fifo_dout.data;
      busy_d[fifo_dout.dst]  = 1'b0;
    end else if (bypass) begin
      regwrite_d          = (bus.lu_dst != '0);
      dst_d               = bus.lu_dst;
      regwd_d             = bus.lu_data;
      busy_d[bus.lu_dst]  = 1'b0;
    end
    if (bus.issue_valid && (bus.issue_dst != '0)) busy_d[bus.issue_dst] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      regwrite_q <= 1'b0;
      dst_q      <= '0;
      regwd_q    <= '0;
      busy_q     <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      dst_q      <= dst_d;
      regwd_q    <= regwd_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.regwrite_wb = regwrite_q;
  assign bus.dst_wb      = dst_q;
  assign bus.regwd_wb    = regwd_q;
  assign bus.busy_vec    = busy_q;
  assign bus.fifo_count  = fifo_count;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus random traffic vs a queue model.
module tb_wb_port_arbiter;

  localparam int DW    = 64;
  localparam int AW    = 5;
  localparam int DEPTH = 4;

  typedef struct {
    logic [AW-1:0] dst;
    logic [DW-1:0] data;
  } entry_t;

  logic clk;
  logic rstn;
  int   tests;
  int   fails;

  wb_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) bus ();

  wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending results queue, busy set and the last port write.
  entry_t        m_q[$];
  logic [31:0]   m_busy;
  logic          m_we;
  logic [AW-1:0] m_dst;
  logic [DW-1:0] m_data;

  task automatic model_reset();
    m_q.delete();
    m_busy = '0;
    m_we   = 1'b0;
    m_dst  = '0;
    m_data = '0;
  endtask

  // Drives one cycle of stimulus (called just after a negedge) and advances the model at the posedge.
  task automatic cycle(input logic pv, input logic [AW-1:0] pd, input logic [DW-1:0] pdat,
                       input logic lv, input logic [AW-1:0] ld, input logic [DW-1:0] ldat,
                       input logic iv, input logic [AW-1:0] id);
    entry_t e;
    bit rdy, acc, byp;
    bus.pipe_valid  = pv;
    bus.pipe_dst    = pd;
    bus.pipe_data   = pdat;
    bus.lu_valid    = lv;
    bus.lu_dst      = ld;
    bus.lu_data     = ldat;
    bus.issue_valid = iv;
    bus.issue_dst   = id;
    rdy = (m_q.size() < DEPTH);
    acc = lv && rdy;
    byp = 1'b0;
`ifdef WB_FIFO_BYPASS_EN
    byp = acc && (m_q.size() == 0) && !pv;
`endif
    @(posedge clk);
    if (pv) begin
      m_we = 1'b1; m_dst = pd; m_data = pdat;
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_we = (e.dst != 0); m_dst = e.dst; m_data = e.data;
      m_busy[e.dst] = 1'b0;
    end else if (byp) begin
      m_we = (ld != 0); m_dst = ld; m_data = ldat;
      m_busy[ld] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (acc && !byp) begin
      e.dst = ld; e.data = ldat;
      m_q.push_back(e);
    end
    if (iv && id != 0) m_busy[id] = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    tests++;
    if (bus.regwrite_wb !== 1'b0 || bus.dst_wb !== '0 || bus.regwd_wb !== '0) begin
      fails++;
      $display("[TB] FAIL reset_port: got we=%b dst=%0d data=%0h expected 0/0/0", bus.regwrite_wb, bus.dst_wb, bus.regwd_wb);
    end
    tests++;
    if (bus.busy_vec !== 32'h0 || bus.fifo_count !== 3'd0 || bus.lu_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_state: got busy=%h count=%0d ready=%b expected 0/0/0", bus.busy_vec, bus.fifo_count, bus.lu_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    tests++;
    if (bus.lu_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_release_ready: got %b expected 1", bus.lu_ready);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.pipe_valid = 0; bus.pipe_dst = '0; bus.pipe_data = '0;
    bus.lu_valid = 0; bus.lu_dst = '0; bus.lu_data = '0;
    bus.issue_valid = 0; bus.issue_dst = '0;
  endtask

  task automatic test_pipe();
    cycle(1'b1, 5'd5, 64'hDEAD, 1'b0, '0, '0, 1'b0, '0);
    tests++;
    if (bus.regwrite_wb !== 1'b1 || bus.dst_wb !== 5'd5 || bus.regwd_wb !== 64'hDEAD) begin
      fails++;
      $display("[TB] FAIL pipe_write: got we=%b dst=%0d data=%0h expected 1/5/dead", bus.regwrite_wb, bus.dst_wb, bus.regwd_wb);
    end
    idle();
    tests++;
    if (bus.regwrite_wb !== 1'b0 || bus.dst_wb !== 5'd5) begin
      fails++;
      $display("[TB] FAIL pipe_idle: got we=%b dst=%0d expected 0/5", bus.regwrite_wb, bus.dst_wb);
    end
  endtask

  task automatic test_lu_busy();
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
    tests++;
    if (bus.busy_vec[7] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL busy_set: got %b expected 1", bus.busy_vec[7]);
    end
    cycle(1'b0, '0, '0, 1'b1, 5'd7, 64'h1234, 1'b0, '0);
`ifndef WB_FIFO_BYPASS_EN
    tests++;
    if (bus.regwrite_wb !== 1'b0 || bus.busy_vec[7] !== 1'b1 || bus.fifo_count !== 3'd1) begin
      fails++;
      $display("[TB] FAIL lu_buffered: got we=%b busy7=%b count=%0d expected 0/1/1", bus.regwrite_wb, bus.busy_vec[7], bus.fifo_count);
    end
    idle();
`endif
    tests++;
    if (bus.regwrite_wb !== 1'b1 || bus.dst_wb !== 5'd7 || bus.regwd_wb !== 64'h1234 || bus.busy_vec[7] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL lu_write: got we=%b dst=%0d data=%0h busy7=%b expected 1/7/1234/0", bus.regwrite_wb, bus.dst_wb, bus.regwd_wb, bus.busy_vec[7]);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      tests++;
      if (bus.lu_ready !== 1'b1) begin
        fails++;
        $display("[TB] FAIL fill_ready_%0d: got %b expected 1", i, bus.lu_ready);
      end
      cycle(1'b1, 5'd3, 64'(i), 1'b1, 5'(10 + i), 64'(256 + i), 1'b0, '0);
    end
    tests++;
    if (bus.fifo_count !== 3'd4 || bus.lu_ready !== 1'b0 || bus.dst_wb !== 5'd3) begin
      fails++;
      $display("[TB] FAIL fill_full: got count=%0d ready=%b dst=%0d expected 4/0/3", bus.fifo_count, bus.lu_ready, bus.dst_wb);
    end
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      tests++;
      if (bus.regwrite_wb !== 1'b1 || bus.dst_wb !== 5'(10 + i) || bus.regwd_wb !== 64'(256 + i)) begin
        fails++;
        $display("[TB] FAIL drain_%0d: got we=%b dst=%0d data=%0h expected 1/%0d/%0h", i, bus.regwrite_wb, bus.dst_wb, bus.regwd_wb, 10 + i, 256 + i);
      end
      tests++;
      if (bus.fifo_count !== 3'(3 - i) || bus.lu_ready !== 1'b1) begin
        fails++;
        $display("[TB] FAIL drain_count_%0d: got count=%0d ready=%b expected %0d/1", i, bus.fifo_count, bus.lu_ready, 3 - i);
      end
    end
  endtask

  task automatic test_same_cycle();
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9);
    cycle(1'b1, 5'd2, 64'h2, 1'b1, 5'd9, 64'h99, 1'b0, '0);
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9);
    tests++;
    if (bus.regwrite_wb !== 1'b1 || bus.dst_wb !== 5'd9 || bus.busy_vec[9] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL set_wins: got we=%b dst=%0d busy9=%b expected 1/9/1", bus.regwrite_wb, bus.dst_wb, bus.busy_vec[9]);
    end
  endtask

  task automatic test_x0();
    cycle(1'b1, 5'd4, 64'h4, 1'b1, 5'd0, 64'h55, 1'b0, '0);
    tests++;
    if (bus.fifo_count !== 3'd1) begin
      fails++;
      $display("[TB] FAIL x0_push: got count=%0d expected 1", bus.fifo_count);
    end
    idle();
    tests++;
    if (bus.fifo_count !== 3'd0 || bus.regwrite_wb !== 1'b0) begin
      fails++;
      $display("[TB] FAIL x0_pop: got count=%0d we=%b expected 0/0", bus.fifo_count, bus.regwrite_wb);
    end
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd0);
    tests++;
    if (bus.busy_vec[0] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL x0_busy: got %b expected 0", bus.busy_vec[0]);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 5'd1, 64'h1, 1'b1, 5'(20 + i), 64'(i), 1'b1, 5'(20 + i));
    tests++;
    if (bus.fifo_count !== 3'd3 || bus.busy_vec[22:20] !== 3'b111) begin
      fails++;
      $display("[TB] FAIL mid_setup: got count=%0d busy=%b expected 3/111", bus.fifo_count, bus.busy_vec[22:20]);
    end
    idle_inputs();
    rstn = 1'b0;
    model_reset();
    #1;
    tests++;
    if (bus.fifo_count !== 3'd0 || bus.busy_vec !== 32'h0 || bus.lu_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_reset: got count=%0d busy=%h ready=%b expected 0/0/0", bus.fifo_count, bus.busy_vec, bus.lu_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      tests++;
      if (bus.regwrite_wb !== 1'b0) begin
        fails++;
        $display("[TB] FAIL stale_write_%0d: got we=%b dst=%0d expected 0", i, bus.regwrite_wb, bus.dst_wb);
      end
    end
  endtask

  task automatic test_random();
    logic          lv, pv, iv;
    logic [AW-1:0] ld, pd, id;
    logic [DW-1:0] ldat, pdat;
    bit            rdy;
    lv = 0; ld = '0; ldat = '0;
    for (int n = 0; n < 1500; n++) begin
      pv   = ($urandom_range(0, 9) < 4);
      pd   = 5'($urandom_range(0, 31));
      pdat = {$urandom, $urandom};
      iv   = ($urandom_range(0, 9) < 3);
      id   = 5'($urandom_range(0, 31));
      rdy  = (m_q.size() < DEPTH);
      cycle(pv, pd, pdat, lv, ld, ldat, iv, id);
      tests++;
      if (bus.regwrite_wb !== m_we || bus.dst_wb !== m_dst || bus.regwd_wb !== m_data) begin
        fails++;
        $display("[TB] FAIL rand_port_%0d: got we=%b dst=%0d data=%0h expected %b/%0d/%0h", n, bus.regwrite_wb, bus.dst_wb, bus.regwd_wb, m_we, m_dst, m_data);
      end
      tests++;
      if (bus.busy_vec !== m_busy) begin
        fails++;
        $display("[TB] FAIL rand_busy_%0d: got %h expected %h", n, bus.busy_vec, m_busy);
      end
      tests++;
      if (bus.fifo_count !== 3'(m_q.size()) || bus.lu_ready !== (m_q.size() < DEPTH)) begin
        fails++;
        $display("[TB] FAIL rand_fifo_%0d: got count=%0d ready=%b expected %0d/%b", n, bus.fifo_count, bus.lu_ready, m_q.size(), m_q.size() < DEPTH);
      end
      // Offer is held until accepted, then replaced.
      if (!lv || rdy) begin
        lv   = ($urandom_range(0, 1) == 1);
        ld   = 5'($urandom_range(0, 31));
        ldat = {$urandom, $urandom};
      end
    end
    idle_inputs();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_pipe();
    test_lu_busy();
    test_fill();
    test_same_cycle();
    test_x0();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
